// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Includes the fetch-buffer entry that pairs each PC with its instruction word.
package ifetch_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small fetch buffer with synchronous push/pop and a flush input.
// The head entry reads as zero whenever the buffer is empty.
module fetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  fetch_entry_t  mem_q [DEPTH];

  logic do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);

  // A pop frees a slot in the same cycle, so a full buffer may still accept a push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: PC register, fetch/redirect control and output mapping
// around a small fetch buffer feeding decode through a valid/ready handshake.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] imem_a,
  input  logic [ILEN-1:0] imem_rd,
  input  logic            redirect,
  input  logic [XLEN-1:0] pc_target,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pcplus4
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            full, empty, pop, fire;
  fetch_entry_t    push_entry, head;

  assign pop  = out_valid && out_ready;
  assign fire = !redirect && (!full || pop);

  assign push_entry.pc    = pc_q;
  assign push_entry.instr = imem_rd;

  always_comb begin
    pc_d = pc_q;
    if (redirect)  pc_d = {pc_target[XLEN-1:2], 2'b00};
    else if (fire) pc_d = pc_q + 32'd4;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  // A handshake in a redirect cycle still retires the head; flush drops the rest.
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .push      (fire),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

  assign imem_a      = pc_q;
  assign out_valid   = !empty;
  assign out_pc      = head.pc;
  assign out_instr   = head.instr;
  assign out_pcplus4 = empty ? '0 : head.pc + 32'd4;

endmodule
